// File: rtl/dmux_4way.sv
// dmux_4way: 1-to-4 demultiplexer with saturating per-lane activity counters.
// Define DMUX4WAY_REG_OUT_EN to register a/b/c/d (1-cycle latency, async clear).
module dmux_4way #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       sel,
    input  logic             clr,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_d
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0][WIDTH-1:0] w_lane;
    logic [NUM_LANES-1:0][WIDTH-1:0] w_out;
    logic [NUM_LANES-1:0][CNT_W-1:0] w_cnt;
    logic                            w_active;

    assign w_active = |in;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        localparam logic [1:0] LANE = 2'(g);
        logic [CNT_W-1:0] r_cnt;
        logic             w_hit;

        assign w_lane[g] = (sel == LANE) ? in : '0;
        assign w_hit     = (sel == LANE) && w_active;

        // clr beats increment; all-ones is the saturation ceiling
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                r_cnt <= '0;
            else if (clr)
                r_cnt <= '0;
            else if (w_hit && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
        end
        assign w_cnt[g] = r_cnt;

`ifdef DMUX4WAY_REG_OUT_EN
        logic [WIDTH-1:0] r_out;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                r_out <= '0;
            else
                r_out <= w_lane[g];
        end
        assign w_out[g] = r_out;
`else
        assign w_out[g] = w_lane[g];
`endif
    end

    assign a     = w_out[0];
    assign b     = w_out[1];
    assign c     = w_out[2];
    assign d     = w_out[3];
    assign cnt_a = w_cnt[0];
    assign cnt_b = w_cnt[1];
    assign cnt_c = w_cnt[2];
    assign cnt_d = w_cnt[3];
endmodule

// File: tb/tb_dmux_4way.sv
// Self-checking bench for dmux_4way: behavioural model plus directed literal checks.
// Follows DMUX4WAY_REG_OUT_EN the same way the design does.
module tb_dmux_4way;
    localparam int WIDTH = 1;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] t_in;
    logic [1:0]       sel;
    logic             clr;
    logic [WIDTH-1:0] a, b, c, d;
    logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c, cnt_d;

    int total = 0;
    int bad   = 0;
    bit go    = 1'b0;

    // model state
    int m_cnt [4] = '{0, 0, 0, 0};
    int m_reg [4] = '{0, 0, 0, 0};

    dmux_4way #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in(t_in), .sel(sel), .clr(clr),
        .a(a), .b(b), .c(c), .d(d),
        .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // what lane 'lane' must show for a given in/sel
    function automatic int route(input int v, input int s, input int lane);
        return (s == lane) ? v : 0;
    endfunction

    function automatic int dut_out(input int lane);
        case (lane)
            0: return int'(a);
            1: return int'(b);
            2: return int'(c);
            default: return int'(d);
        endcase
    endfunction

    function automatic int dut_cnt(input int lane);
        case (lane)
            0: return int'(cnt_a);
            1: return int'(cnt_b);
            2: return int'(cnt_c);
            default: return int'(cnt_d);
        endcase
    endfunction

    // model: counters and sampled outputs update on the clock, cleared by reset level
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) m_reg[i] = route(int'(t_in), int'(sel), i);
            if (clr) begin
                for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            end else if (t_in != 0 && m_cnt[sel] < CMAX) begin
                m_cnt[sel] = m_cnt[sel] + 1;
            end
        end
    end
    always @(posedge reset) begin
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_reg[i] = 0;
        end
    end

    // compare process: every falling edge once running
    always @(negedge clk) begin
        if (go) begin
            int ored;
            ored = 0;
            for (int i = 0; i < 4; i++) begin
`ifdef DMUX4WAY_REG_OUT_EN
                check($sformatf("out%0d", i), dut_out(i), reset ? 0 : m_reg[i]);
`else
                check($sformatf("out%0d", i), dut_out(i), route(int'(t_in), int'(sel), i));
                ored = ored | dut_out(i);
`endif
                check($sformatf("cnt%0d", i), dut_cnt(i), m_cnt[i]);
            end
`ifndef DMUX4WAY_REG_OUT_EN
            check("or_eq_in", ored, int'(t_in));
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        reset = 1'b1; t_in = '0; sel = 2'b00; clr = 1'b0;
        #12;
        check("rst_cnt_a", int'(cnt_a), 0);
        check("rst_cnt_d", int'(cnt_d), 0);
`ifdef DMUX4WAY_REG_OUT_EN
        check("rst_out_d", int'(d), 0);
`endif
        reset = 1'b0;
        go = 1'b1;
        cyc(1);

        // in=0 over every sel: everything stays zero
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s); t_in = '0;
            cyc(1);
            check("zero_or", int'(a | b | c | d), 0);
            check("zero_cnt_sum", int'(cnt_a) + int'(cnt_b) + int'(cnt_c) + int'(cnt_d), 0);
        end

`ifndef DMUX4WAY_REG_OUT_EN
        // one-hot routing settles within 1 time unit
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s); t_in = 1'b1;
            #1;
            check("onehot_abcd", int'({a, b, c, d}), 8 >> s);
            cyc(1);
        end
`endif

        // cnt_b up to 5, then async reset mid-cycle
        clr = 1'b1; cyc(1); clr = 1'b0;
        sel = 2'b01; t_in = 1'b1;
        cyc(5);
        check("cnt_b_5", int'(cnt_b), 5);
        t_in = 1'b1; sel = 2'b01;
        #1 reset = 1'b1;
        #1;
        check("async_cnt_b", int'(cnt_b), 0);
`ifdef DMUX4WAY_REG_OUT_EN
        check("rst_regout_b", int'(b), 0);
`else
        check("rst_keep_b", int'(b), 1);
`endif
        cyc(2);
        check("hold_rst_cnt_b", int'(cnt_b), 0);
        reset = 1'b0;
        cyc(1);
        check("resume_cnt_b", int'(cnt_b), 1);

        // saturation on lane c
        clr = 1'b1; cyc(1); clr = 1'b0;
        sel = 2'b10; t_in = 1'b1;
        cyc(300);
        check("sat_cnt_c", int'(cnt_c), 255);
        check("sat_cnt_a", int'(cnt_a), 0);
        check("sat_cnt_b", int'(cnt_b), 0);
        check("sat_cnt_d", int'(cnt_d), 0);

        // clr beats a simultaneous increment
        sel = 2'b00; t_in = 1'b1; clr = 1'b1;
        cyc(1);
        clr = 1'b0; t_in = '0;
        check("clr_prio_sum", int'(cnt_a) + int'(cnt_b) + int'(cnt_c) + int'(cnt_d), 0);

`ifdef DMUX4WAY_REG_OUT_EN
        // registered outputs: one edge of latency, async clear
        t_in = '0; sel = 2'b00; cyc(1);
        t_in = 1'b1; sel = 2'b11;
        #1;
        check("reg_d_before", int'(d), 0);
        @(posedge clk); #1;
        check("reg_abcd_after", int'({a, b, c, d}), 1);
        #1 reset = 1'b1;
        #1;
        check("reg_rst_abcd", int'({a, b, c, d}), 0);
        cyc(1);
        reset = 1'b0;
        cyc(1);
`endif

        // random traffic
        for (int k = 0; k < 600; k++) begin
            t_in = WIDTH'($urandom_range(0, 1));
            sel  = 2'($urandom_range(0, 3));
            clr  = ($urandom_range(0, 99) < 3);
            cyc(1);
        end
        clr = 1'b0;

        go = 1'b0;
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
